// File: rtl/reg_bank16.sv
// reg_bank16: 16x16 register file with per-register pending-claim scoreboard and write counter.
module reg_bank16 #(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        claim_en,
  input  logic [3:0]  claim_addr,
  output logic [15:0] ra,
  output logic [15:0] rb,
  output logic [15:0] rc,
  output logic [15:0] rd,
  output logic [15:0] re,
  output logic [15:0] rf,
  output logic [15:0] rg,
  output logic [15:0] rh,
  output logic [15:0] ri,
  output logic [15:0] rj,
  output logic [15:0] rk,
  output logic [15:0] rl,
  output logic [15:0] rm,
  output logic [15:0] rn,
  output logic [15:0] ro,
  output logic [15:0] rp,
  output logic [15:0] busy,
  output logic [7:0]  wr_count
);
  logic [15:0] regs [16];
  logic [15:0] we;
  logic [15:0] cl;
  // Enables gate the decode so an undefined address with its strobe low selects nothing.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      we[i] = wr_en && (wr_addr == 4'(i)) && !(ZERO_REG && i == 0);
      cl[i] = claim_en && (claim_addr == 4'(i)) && !(ZERO_REG && i == 0);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      busy     <= '0;
      wr_count <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (we[i]) regs[i] <= wr_data;
      busy     <= (busy & ~we) | cl;
      wr_count <= wr_count + 8'(|we);
    end
  end
  assign ra = regs[0];
  assign rb = regs[1];
  assign rc = regs[2];
  assign rd = regs[3];
  assign re = regs[4];
  assign rf = regs[5];
  assign rg = regs[6];
  assign rh = regs[7];
  assign ri = regs[8];
  assign rj = regs[9];
  assign rk = regs[10];
  assign rl = regs[11];
  assign rm = regs[12];
  assign rn = regs[13];
  assign ro = regs[14];
  assign rp = regs[15];
endmodule

// File: doc/reg_bank16.md
REG_BANK16 -- requirements
Module: reg_bank16

Interface
REQ-001 Parameter ZERO_REG, default 1: when 1, register 0 (ra) SHALL read constant 0x0000 and ignore writes and claims.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr_en  input  1  write-back strobe.
REQ-005 wr_addr  input  4  write-back destination register index.
REQ-006 wr_data  input  16  write-back value.
REQ-007 claim_en  input  1  marks a destination as pending (load/multi-cycle result in flight).
REQ-008 claim_addr  input  4  register index being claimed.
REQ-009 ra..rp  output  16 each  current contents of registers 0..15, in that order, for the downstream 16:1 read select.
REQ-010 busy  output  16  bit i SHALL be 1 while register i has an outstanding claim.
REQ-011 wr_count  output  8  count of accepted writes, modulo 256.

Function
REQ-012 Each register SHALL be a 16-bit flop; outputs ra..rp SHALL be driven directly from the flops, with no combinational path from wr_data.
REQ-013 On a rising edge with wr_en=1, the register at wr_addr SHALL take wr_data; the new value SHALL appear on its output in the following cycle (1-cycle latency, no write-through bypass).
REQ-014 A write with wr_en=1 SHALL clear busy[wr_addr] on the same edge, unless REQ-016 applies.
REQ-015 A rising edge with claim_en=1 SHALL set busy[claim_addr].
REQ-016 Simultaneous write and claim to the same address: data SHALL be written and busy SHALL end at 1; the claim wins.
REQ-017 Simultaneous write and claim to different addresses: both SHALL take effect independently.
REQ-018 Claiming an already-busy register SHALL leave it busy; no nesting depth is tracked.
REQ-019 A write to a non-busy register SHALL be legal and SHALL update data, leaving busy at 0.
REQ-020 With ZERO_REG=1, writes and claims to address 0 SHALL be discarded, ra SHALL remain 0x0000, busy[0] SHALL remain 0, and wr_count SHALL NOT increment.
REQ-021 With ZERO_REG=0, register 0 SHALL behave as every other register.
REQ-022 wr_count SHALL increment by 1 on each accepted write.
REQ-023 wr_count SHALL wrap from 255 to 0.
REQ-024 Registers with no write on an edge SHALL hold their value.
REQ-025 Inputs with wr_en=0 and claim_en=0 SHALL have no effect.
REQ-026 X on wr_addr or claim_addr while the matching enable is 0 SHALL NOT corrupt state.

Reset
REQ-027 Assertion of rst SHALL immediately clear all sixteen registers to 0x0000, busy to 0x0000 and wr_count to 0, without waiting for clk.
REQ-028 Writes and claims SHALL be ignored while rst=1.
REQ-029 A reset asserted mid-operation SHALL discard all pending claims.
REQ-030 The first edge after rst deasserts SHALL process inputs normally.

Verification
REQ-031 Reset scenario: assert rst between clock edges -> ra..rp=0x0000, busy=0x0000 and wr_count=0 before the next edge.
REQ-032 Write scenario: write 0xBEEF to index 5 -> rf=0xBEEF one cycle later, all other outputs unchanged, wr_count=1.
REQ-033 Claim/release scenario: claim index 9 -> busy=0x0200; next cycle write 0x1234 to index 9 -> busy=0x0000 and rj=0x1234.
REQ-034 Collision scenario: same-edge write of 0x00AA and claim to index 3 -> rd=0x00AA and busy[3]=1.
REQ-035 Zero-register scenario (ZERO_REG=1): write 0xFFFF and claim to index 0 -> ra=0x0000, busy[0]=0, wr_count unchanged.
REQ-036 Counter wrap scenario: 256 writes to index 1 with data equal to the loop index -> wr_count=0 and rb=0x00FF.
